// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared constants and types for the RV32I load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  // RV32I opcodes handled by the memory stage
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/load_store_unit_align.sv
// ============================================================================
// Module      : load_store_unit_align
// Description : Combinational lane steering. Builds store data and byte mask,
//               extracts and extends load data, flags illegal/misaligned ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic [31:0] rdata_ext,
  output logic        fault
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = rdata[{offset, 3'b000} +: 8];
  assign sel_half = rdata[{offset[1], 4'b0000} +: 16];

  // Decode access size, lane placement and legality
  always_comb begin
    wdata     = '0;
    wmask     = '0;
    rdata_ext = '0;
    fault     = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          wdata = {4{rs2[7:0]}};
          wmask = 4'b0001 << offset;
        end
        F3_H: begin
          fault = offset[0];
          wdata = {2{rs2[15:0]}};
          wmask = 4'b0011 << {offset[1], 1'b0};
        end
        F3_W: begin
          fault = |offset;
          wdata = rs2;
          wmask = 4'b1111;
        end
        default: fault = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:  rdata_ext = {{24{sel_byte[7]}}, sel_byte};
        F3_BU: rdata_ext = {24'd0, sel_byte};
        F3_H: begin
          fault     = offset[0];
          rdata_ext = {{16{sel_half[15]}}, sel_half};
        end
        F3_HU: begin
          fault     = offset[0];
          rdata_ext = {16'd0, sel_half};
        end
        F3_W: begin
          fault     = |offset;
          rdata_ext = rdata;
        end
        default: fault = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : RV32I memory stage. Accepts one LOAD/STORE at a time, runs a
//               single word access on the data port, returns extended data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_rs1,
  input  logic [31:0]       req_rs2,
  input  logic [31:0]       req_imm,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  lsu_state_t  state;
  logic [1:0]  offset_q;
  logic [2:0]  funct3_q;
  logic        is_store_q;

  logic [31:0] ea;
  logic        sel_store;
  logic [2:0]  sel_funct3;
  logic [1:0]  sel_offset;
  logic [31:0] al_wdata;
  logic [3:0]  al_wmask;
  logic [31:0] al_rdata_ext;
  logic        al_fault;

  assign ea = req_rs1 + req_imm;

  // In IDLE the aligner sees the incoming request (store lanes, legality);
  // afterwards it sees the latched request so load data can be extended.
  assign sel_store  = (state == IDLE) ? req_is_store : is_store_q;
  assign sel_funct3 = (state == IDLE) ? req_funct3   : funct3_q;
  assign sel_offset = (state == IDLE) ? ea[1:0]      : offset_q;

  load_store_unit_align u_align (
    .is_store  (sel_store),
    .funct3    (sel_funct3),
    .offset    (sel_offset),
    .rs2       (req_rs2),
    .rdata     (mem_rdata),
    .wdata     (al_wdata),
    .wmask     (al_wmask),
    .rdata_ext (al_rdata_ext),
    .fault     (al_fault)
  );

  // Controller with registered memory-port and response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      offset_q   <= '0;
      funct3_q   <= '0;
      is_store_q <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            offset_q   <= ea[1:0];
            funct3_q   <= req_funct3;
            is_store_q <= req_is_store;
            req_ready  <= 1'b0;
            if (al_fault) begin
              // Faults skip the memory port entirely
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state     <= ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= req_is_store;
              mem_addr  <= {ea[ADDR_W-1:2], 2'b00};
              mem_wdata <= req_is_store ? al_wdata : 32'd0;
              mem_wmask <= req_is_store ? al_wmask : 4'd0;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_wmask  <= '0;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= is_store_q ? 32'd0 : al_rdata_ext;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit with a word-level
//               reference model and randomized transactions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1, req_rs2, req_imm;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {
    logic        ready0;
    logic        seen_req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        stable;
    int          lat;
    logic [31:0] rdata;
    logic        fault;
    logic        req_at_resp;
    logic        pulse_ok;
    logic        ready_after;
  } obs_t;

  typedef struct {
    logic        fault;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  // Reference model: sizes, lanes and extension from plain arithmetic
  function automatic exp_t model(input logic st, input logic [2:0] f3,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [31:0] rdata,
                                 input int delay);
    exp_t e;
    logic [31:0] ea, sh, v;
    int size, off;
    bit sgn;
    ea   = rs1 + imm;
    off  = int'(ea % 4);
    size = 0;
    sgn  = 0;
    if (st) begin
      if (f3 == 3'd0) size = 1;
      else if (f3 == 3'd1) size = 2;
      else if (f3 == 3'd2) size = 4;
    end else begin
      if (f3 == 3'd0) begin size = 1; sgn = 1; end
      else if (f3 == 3'd1) begin size = 2; sgn = 1; end
      else if (f3 == 3'd2) size = 4;
      else if (f3 == 3'd4) size = 1;
      else if (f3 == 3'd5) size = 2;
    end
    e.fault = (size == 0) || (off % size != 0);
    e.addr  = ea - 32'(off);
    e.wdata = 32'd0;
    e.wmask = 4'd0;
    e.rdata = 32'd0;
    e.lat   = e.fault ? 1 : 2 + delay;
    if (!e.fault && st) begin
      if (size == 1) begin
        e.wdata = (rs2 & 32'hFF) * 32'h0101_0101;
        e.wmask = 4'(1 << off);
      end else if (size == 2) begin
        e.wdata = (rs2 & 32'hFFFF) * 32'h0001_0001;
        e.wmask = 4'(3 << off);
      end else begin
        e.wdata = rs2;
        e.wmask = 4'hF;
      end
    end
    if (!e.fault && !st) begin
      sh = rdata >> (8 * off);
      if (size == 1) begin
        v = sh & 32'hFF;
        if (sgn && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end else if (size == 2) begin
        v = sh & 32'hFFFF;
        if (sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end else begin
        v = rdata;
      end
      e.rdata = v;
    end
    return e;
  endfunction

  // Drive one request and play the memory side; records what was observed
  task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [31:0] rdata, input int delay, output obs_t o);
    int first_c;
    bit done;
    o = '{ready0: 0, seen_req: 0, we: 0, addr: 0, wdata: 0, wmask: 0, stable: 1,
          lat: -1, rdata: 0, fault: 0, req_at_resp: 0, pulse_ok: 0, ready_after: 0};
    first_c = -1;
    done = 0;
    @(negedge clk);
    o.ready0     = req_ready;
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_rs1      = rs1;
    req_rs2      = rs2;
    req_imm      = imm;
    @(negedge clk);
    req_valid = 1'b0;
    req_rs2   = $urandom;
    for (int c = 1; c <= 30 && !done; c++) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (resp_valid) begin
        o.lat = c;
        o.rdata = resp_rdata;
        o.fault = resp_fault;
        o.req_at_resp = mem_req;
        done = 1;
      end else begin
        if (mem_req) begin
          if (first_c < 0) begin
            first_c = c;
            o.seen_req = 1'b1;
            o.we = mem_we;
            o.addr = mem_addr;
            o.wdata = mem_wdata;
            o.wmask = mem_wmask;
          end else if (mem_we !== o.we || mem_addr !== o.addr ||
                       mem_wdata !== o.wdata || mem_wmask !== o.wmask) begin
            o.stable = 1'b0;
          end
          if (c - first_c >= delay) begin
            mem_ready = 1'b1;
            mem_rdata = rdata;
          end
        end
        @(negedge clk);
      end
    end
    mem_ready = 1'b0;
    @(negedge clk);
    o.pulse_ok    = !resp_valid;
    o.ready_after = req_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
    req_rs1 = '0; req_rs2 = '0; req_imm = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({req_ready, resp_valid, resp_fault, mem_req, mem_we} !== 5'b10000)
      $display("FAIL reset_ctrl got %b exp 10000", {req_ready, resp_valid, resp_fault, mem_req, mem_we});
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr, mem_wdata, mem_wmask, resp_rdata} !== '0)
      $display("FAIL reset_data got addr=%h wdata=%h wmask=%h rdata=%h exp 0",
               mem_addr, mem_wdata, mem_wmask, resp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_lw();
    obs_t o;
    do_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'h4, 32'hDEAD_BEEF, 3, o);
    total_cnt++;
    if (o.addr !== 32'h104 || o.wmask !== 4'h0 || o.we !== 1'b0 || !o.ready0)
      $display("FAIL lw_port got addr=%h wmask=%h we=%b exp 104/0/0", o.addr, o.wmask, o.we);
    else pass_cnt++;
    total_cnt++;
    if (o.rdata !== 32'hDEAD_BEEF || o.fault !== 1'b0)
      $display("FAIL lw_data got %h fault=%b exp deadbeef/0", o.rdata, o.fault);
    else pass_cnt++;
    total_cnt++;
    if (o.lat !== 5 || !o.stable || o.req_at_resp !== 1'b0 || !o.pulse_ok || !o.ready_after)
      $display("FAIL lw_timing got lat=%0d stable=%b req=%b pulse=%b exp 5/1/0/1",
               o.lat, o.stable, o.req_at_resp, o.pulse_ok);
    else pass_cnt++;
  endtask

  task automatic test_load_ext();
    obs_t o;
    do_txn(1'b0, 3'b000, 32'h100, 32'h0, 32'h3, 32'h8011_2233, 1, o);
    total_cnt++;
    if (o.rdata !== 32'hFFFF_FF80 || o.addr !== 32'h100)
      $display("FAIL lb got %h addr=%h exp ffffff80/100", o.rdata, o.addr);
    else pass_cnt++;
    do_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h0, 32'h8011_2233, 0, o);
    total_cnt++;
    if (o.rdata !== 32'h0000_0080)
      $display("FAIL lbu got %h exp 00000080", o.rdata);
    else pass_cnt++;
    do_txn(1'b0, 3'b001, 32'h104, 32'h0, 32'hFFFF_FFFE, 32'h8011_2233, 2, o);
    total_cnt++;
    if (o.rdata !== 32'hFFFF_8011 || o.fault !== 1'b0)
      $display("FAIL lh got %h fault=%b exp ffff8011/0", o.rdata, o.fault);
    else pass_cnt++;
  endtask

  task automatic test_stores();
    obs_t o;
    do_txn(1'b1, 3'b000, 32'h200, 32'h1234_5678, 32'h1, 32'h0, 1, o);
    total_cnt++;
    if (o.addr !== 32'h200 || o.wdata !== 32'h7878_7878 || o.wmask !== 4'b0010 || o.we !== 1'b1)
      $display("FAIL sb got addr=%h wdata=%h wmask=%b we=%b exp 200/78787878/0010/1",
               o.addr, o.wdata, o.wmask, o.we);
    else pass_cnt++;
    do_txn(1'b1, 3'b001, 32'h202, 32'h1234_5678, 32'h0, 32'h0, 0, o);
    total_cnt++;
    if (o.wdata !== 32'h5678_5678 || o.wmask !== 4'b1100 || o.rdata !== 32'h0 || o.lat !== 2)
      $display("FAIL sh got wdata=%h wmask=%b rdata=%h lat=%0d exp 56785678/1100/0/2",
               o.wdata, o.wmask, o.rdata, o.lat);
    else pass_cnt++;
    // effective address wraps modulo 2^32
    do_txn(1'b1, 3'b010, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'h8, 32'h0, 0, o);
    total_cnt++;
    if (o.addr !== 32'h4 || o.wdata !== 32'hCAFE_F00D || o.wmask !== 4'hF)
      $display("FAIL sw_wrap got addr=%h wdata=%h wmask=%h exp 4/cafef00d/f", o.addr, o.wdata, o.wmask);
    else pass_cnt++;
  endtask

  task automatic test_faults();
    obs_t o;
    logic [2:0] f3s [3] = '{3'b010, 3'b001, 3'b011};
    logic       sts [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] eas [3] = '{32'h102, 32'h203, 32'h100};
    for (int i = 0; i < 3; i++) begin
      do_txn(sts[i], f3s[i], eas[i], 32'hFFFF_FFFF, 32'h0, 32'h1234_5678, 0, o);
      total_cnt++;
      if (o.fault !== 1'b1 || o.lat !== 1 || o.seen_req !== 1'b0 || o.rdata !== 32'h0 || !o.pulse_ok)
        $display("FAIL fault[%0d] got fault=%b lat=%0d memreq=%b rdata=%h exp 1/1/0/0",
                 i, o.fault, o.lat, o.seen_req, o.rdata);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int acc_c;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
    req_rs1 = 32'h300; req_imm = 32'h0;
    @(negedge clk);
    // second request held while the first is in flight
    req_rs1 = 32'h400;
    total_cnt++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h300 || req_ready !== 1'b0)
      $display("FAIL b2b_first got req=%b addr=%h ready=%b exp 1/300/0", mem_req, mem_addr, req_ready);
    else pass_cnt++;
    mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = 32'h0;
    total_cnt++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hA5A5_0001 || mem_req !== 1'b0 || mem_addr !== 32'h300)
      $display("FAIL b2b_resp got valid=%b rdata=%h req=%b addr=%h exp 1/a5a50001/0/300",
               resp_valid, resp_rdata, mem_req, mem_addr);
    else pass_cnt++;
    acc_c = -1;
    for (int c = 0; c < 6 && acc_c < 0; c++) begin
      @(negedge clk);
      if (mem_req) acc_c = c;
    end
    req_valid = 1'b0;
    total_cnt++;
    if (acc_c !== 1 || mem_addr !== 32'h400)
      $display("FAIL b2b_second got cycle=%0d addr=%h exp 1/400", acc_c, mem_addr);
    else pass_cnt++;
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_CAFE;
    @(negedge clk);
    mem_ready = 1'b0;
    total_cnt++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BAD_CAFE)
      $display("FAIL b2b_second_resp got valid=%b rdata=%h exp 1/0badcafe", resp_valid, resp_rdata);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    int resp_seen;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_rs1 = 32'h500; req_rs2 = 32'h1; req_imm = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total_cnt++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL rst_mid got req=%b ready=%b valid=%b exp 0/1/0", mem_req, req_ready, resp_valid);
    else pass_cnt++;
    resp_seen = 0;
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    mem_ready = 1'b0;
    total_cnt++;
    if (resp_seen !== 0)
      $display("FAIL rst_mid_noresp got %0d responses exp 0", resp_seen);
    else pass_cnt++;
    do_txn(1'b0, 3'b010, 32'h600, 32'h0, 32'h8, 32'h1357_9BDF, 1, o);
    total_cnt++;
    if (o.rdata !== 32'h1357_9BDF || o.addr !== 32'h608 || o.lat !== 3)
      $display("FAIL rst_mid_after got rdata=%h addr=%h lat=%0d exp 13579bdf/608/3", o.rdata, o.addr, o.lat);
    else pass_cnt++;
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic st;
    logic [2:0] f3;
    logic [31:0] rs1, rs2, imm, rd;
    int dly;
    for (int i = 0; i < 60; i++) begin
      st  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      rs1 = $urandom;
      rs2 = $urandom;
      imm = 32'($signed(12'($urandom)));
      rd  = $urandom;
      dly = $urandom_range(0, 3);
      e = model(st, f3, rs1, rs2, imm, rd, dly);
      do_txn(st, f3, rs1, rs2, imm, rd, dly, o);
      total_cnt++;
      if (o.fault !== e.fault || o.lat !== e.lat || o.rdata !== e.rdata || !o.pulse_ok || !o.ready0)
        $display("FAIL rand_resp[%0d] got fault=%b lat=%0d rdata=%h exp %b/%0d/%h",
                 i, o.fault, o.lat, o.rdata, e.fault, e.lat, e.rdata);
      else pass_cnt++;
      if (!e.fault) begin
        total_cnt++;
        if (o.addr !== e.addr || o.we !== st || o.wmask !== e.wmask || !o.stable ||
            (st && o.wdata !== e.wdata))
          $display("FAIL rand_port[%0d] got addr=%h we=%b wmask=%h wdata=%h exp %h/%b/%h/%h",
                   i, o.addr, o.we, o.wmask, o.wdata, e.addr, st, e.wmask, e.wdata);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (o.seen_req !== 1'b0)
          $display("FAIL rand_nomem[%0d] got mem_req=%b exp 0", i, o.seen_req);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_stores();
    test_faults();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
